// File: rtl/cache_pkg.sv
// Shared definitions for the cache miss-fill controller.
//   fill_state_t : controller states (IDLE waits for a miss, FILL services it)
//   WORD_BYTES   : bytes per memory/cache word (16-bit words)
//   BLOCK_BYTES  : block size in bytes at the default of 8 words per block
//   OFFSET_BITS  : byte-offset bits inside a default-sized block
//   block_base() : clears the low offset bits of a byte address
package cache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    localparam int WORD_BYTES  = 2;
    localparam int WORD_SHIFT  = 1;
    localparam int BLOCK_BYTES = WORD_BYTES * 8;
    localparam int OFFSET_BITS = $clog2(BLOCK_BYTES);

    // Align a byte address down to the start of its block. Works on a
    // 32-bit container; callers truncate to their own address width.
    function automatic logic [31:0] block_base(input logic [31:0] addr,
                                               input int unsigned offset_bits);
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF << offset_bits;
        return addr & mask;
    endfunction

endpackage

// File: rtl/beat_counter.sv
// Saturating beat counter used for both the request side and the return
// side of a block fill.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous return to zero (takes priority over enable)
//   enable     : advance by one this cycle
//   count      : current number of beats counted
//   done       : count has reached LIMIT; further enables are ignored
module beat_counter #(
    parameter int LIMIT = 8,
    parameter int CNT_W = $clog2(LIMIT) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    assign done = (count == CNT_W'(LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !done) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// Miss-service controller between the caches and fixed-latency main memory.
// A miss latches the aligned block base and the controller then issues one
// word read per cycle while writing each returned word into the data array;
// the tag array is written alongside the final word, after which the
// controller drops busy and returns to IDLE.
//   clk, rst_n        : clock, asynchronous active-low reset
//   miss_detected     : cache miss this cycle (sampled only in IDLE)
//   miss_address      : byte address that missed
//   memory_data_valid : next in-order read beat is on memory_data
//   memory_data       : returned memory word
//   fsm_busy          : fill in progress, cpu stalls
//   memory_read       : read request this cycle, at memory_address
//   write_data_array  : write cache_data at cache_word_addr this cycle
//   cache_word_addr   : byte address of the word being written
//   cache_data        : word being written (memory_data pass-through)
//   write_tag_array   : single-cycle tag/valid write for the filled block
//   protocol_err      : sticky flag for a beat with no outstanding request
module cache_fill_fsm
    import cache_pkg::*;
#(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LATENCY     = 4,
    parameter int ADDR_W          = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              memory_data_valid,
    input  logic [15:0]       memory_data,
    output logic              fsm_busy,
    output logic              memory_read,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic [ADDR_W-1:0] cache_word_addr,
    output logic [15:0]       cache_data,
    output logic              write_tag_array,
    output logic              protocol_err
);

    localparam int CNT_W     = $clog2(WORDS_PER_BLOCK) + 1;
    localparam int OFFSET_W  = $clog2(WORD_BYTES * WORDS_PER_BLOCK);

    fill_state_t       state;
    logic [ADDR_W-1:0] fill_base;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  recv_cnt;
    logic              issue_done;
    logic              recv_done;
    logic              in_fill;
    logic              issuing;
    logic              beat_ok;
    logic              stray_beat;
    logic              last_beat;

    assign in_fill = (state == FILL);
    assign issuing = in_fill && !issue_done;

    // A beat is accepted only if a request is still outstanding; memory is
    // in-order, so recv_cnt < issue_cnt is exactly that condition.
    assign beat_ok    = in_fill && memory_data_valid && (recv_cnt != issue_cnt) && !recv_done;
    assign stray_beat = memory_data_valid && !beat_ok;
    assign last_beat  = beat_ok && (recv_cnt == CNT_W'(WORDS_PER_BLOCK - 1));

    // Counters are held at zero throughout IDLE, so a fill always starts
    // from zero no matter how the previous one ended.
    beat_counter #(
        .LIMIT (WORDS_PER_BLOCK),
        .CNT_W (CNT_W)
    ) u_issue_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (!in_fill),
        .enable (issuing),
        .count  (issue_cnt),
        .done   (issue_done)
    );

    beat_counter #(
        .LIMIT (WORDS_PER_BLOCK),
        .CNT_W (CNT_W)
    ) u_recv_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (!in_fill),
        .enable (beat_ok),
        .count  (recv_cnt),
        .done   (recv_done)
    );

    // Address outputs are forced to zero when not qualified so that every
    // output reads zero while IDLE and during reset.
    assign fsm_busy         = in_fill;
    assign memory_read      = issuing;
    assign memory_address   = issuing ? fill_base + (ADDR_W'(issue_cnt) << WORD_SHIFT) : '0;
    assign write_data_array = beat_ok;
    assign cache_word_addr  = beat_ok ? fill_base + (ADDR_W'(recv_cnt) << WORD_SHIFT) : '0;
    assign cache_data       = beat_ok ? memory_data : 16'h0000;
    assign write_tag_array  = last_beat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            fill_base    <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (stray_beat) begin
                protocol_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (miss_detected) begin
                        fill_base <= ADDR_W'(block_base(32'(miss_address), OFFSET_W));
                        state     <= FILL;
                    end
                end
                FILL: begin
                    if (last_beat) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with a fixed-latency (4-cycle) in-order
// memory model; returned data is the request address XOR 0x5A5A.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic        fsm_busy;
    logic        memory_read;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [15:0] cache_word_addr;
    logic [15:0] cache_data;
    logic        write_tag_array;
    logic        protocol_err;

    always #5 clk = ~clk;

    cache_fill_fsm dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .fsm_busy          (fsm_busy),
        .memory_read       (memory_read),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .cache_word_addr   (cache_word_addr),
        .cache_data        (cache_data),
        .write_tag_array   (write_tag_array),
        .protocol_err      (protocol_err)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 10;
    logic        stray = 1'b0;
    logic        rd_hist [0:1023];
    logic [15:0] ad_hist [0:1023];

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_hist();
        for (int k = 0; k < 1024; k++) begin
            rd_hist[k] = 1'b0;
            ad_hist[k] = 16'h0000;
        end
    endtask

    // Advance one cycle: drive the memory return for this cycle, let the
    // outputs settle, then record this cycle's request.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (rst_n && rd_hist[cyc-4]) begin
            memory_data_valid = 1'b1;
            memory_data       = ad_hist[cyc-4] ^ 16'h5A5A;
        end else if (rst_n && stray) begin
            memory_data_valid = 1'b1;
            memory_data       = 16'hDEAD;
        end else begin
            memory_data_valid = 1'b0;
            memory_data       = 16'h0000;
        end
        #2;
        rd_hist[cyc] = memory_read;
        ad_hist[cyc] = memory_address;
    endtask

    // Expected outputs in cycle i (1..12) of a fill of block 'base'.
    task automatic check_fill_cycle(input int i, input logic [15:0] base, input logic perr);
        logic        exp_rd;
        logic        exp_wr;
        logic [15:0] ra;
        logic [15:0] wa;
        exp_rd = (i <= 8);
        exp_wr = (i >= 5);
        ra = base + 16'(2 * (i - 1));
        wa = base + 16'(2 * (i - 5));
        chk1("busy", fsm_busy, 1'b1);
        chk1("memory_read", memory_read, exp_rd);
        if (exp_rd) chk16("memory_address", memory_address, ra);
        chk1("write_data_array", write_data_array, exp_wr);
        if (exp_wr) begin
            chk16("cache_word_addr", cache_word_addr, wa);
            chk16("cache_data", cache_data, wa ^ 16'h5A5A);
        end
        chk1("write_tag_array", write_tag_array, (i == 12));
        chk1("protocol_err", protocol_err, perr);
    endtask

    task automatic fill(input logic [15:0] addr, input logic [15:0] base, input logic perr);
        step();
        miss_detected = 1'b1;
        miss_address  = addr;
        chk1("idle_busy", fsm_busy, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i == 1) miss_detected = 1'b0;
            check_fill_cycle(i, base, perr);
        end
        step();
        chk1("post_fill_busy", fsm_busy, 1'b0);
        chk1("post_fill_tag", write_tag_array, 1'b0);
        chk1("post_fill_wr", write_data_array, 1'b0);
    endtask

    initial begin
        clear_hist();
        rst_n             = 1'b0;
        miss_detected     = 1'b0;
        miss_address      = 16'h0000;
        memory_data_valid = 1'b0;
        memory_data       = 16'h0000;
        #1;
        chk1("rst_busy", fsm_busy, 1'b0);
        chk1("rst_read", memory_read, 1'b0);
        chk1("rst_tag", write_tag_array, 1'b0);
        chk1("rst_perr", protocol_err, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Basic fill from a mid-block miss address.
        fill(16'h1236, 16'h1230, 1'b0);

        // Block at the top of the address space.
        fill(16'hFFFE, 16'hFFF0, 1'b0);

        // Miss held high with a changing address during a fill.
        step();
        miss_detected = 1'b1;
        miss_address  = 16'h1236;
        for (int i = 1; i <= 12; i++) begin
            step();
            miss_address = 16'h4000;
            check_fill_cycle(i, 16'h1230, 1'b0);
        end
        step();
        chk1("gap_busy", fsm_busy, 1'b0);
        chk1("gap_read", memory_read, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i == 1) miss_detected = 1'b0;
            check_fill_cycle(i, 16'h4000, 1'b0);
        end
        step();
        chk1("second_done_busy", fsm_busy, 1'b0);

        // Reset in cycle 6 of a fill.
        step();
        miss_detected = 1'b1;
        miss_address  = 16'h1236;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i == 1) miss_detected = 1'b0;
            check_fill_cycle(i, 16'h1230, 1'b0);
        end
        rst_n = 1'b0;
        clear_hist();
        #1;
        chk1("abort_busy", fsm_busy, 1'b0);
        chk1("abort_read", memory_read, 1'b0);
        chk16("abort_maddr", memory_address, 16'h0000);
        chk1("abort_wr", write_data_array, 1'b0);
        chk16("abort_waddr", cache_word_addr, 16'h0000);
        chk16("abort_wdata", cache_data, 16'h0000);
        chk1("abort_tag", write_tag_array, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk1("abort_hold_tag", write_tag_array, 1'b0);
            chk1("abort_hold_busy", fsm_busy, 1'b0);
        end
        rst_n = 1'b1;
        fill(16'h0080, 16'h0080, 1'b0);

        // Stray beat while IDLE.
        stray = 1'b1;
        step();
        chk1("stray_wr", write_data_array, 1'b0);
        chk1("stray_perr_before", protocol_err, 1'b0);
        stray = 1'b0;
        step();
        chk1("stray_perr_after", protocol_err, 1'b1);
        chk1("stray_busy", fsm_busy, 1'b0);
        fill(16'h2468, 16'h2460, 1'b1);
        chk1("perr_sticky", protocol_err, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("perr_cleared", protocol_err, 1'b0);
        step();
        rst_n = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
Miss-service controller between the cpu instruction/data caches and multi-cycle main memory.
- On a cache miss it fetches the whole 16-byte block containing the miss address.
- Memory requests are pipelined, one word request per cycle.
- Each returned word is written into the cache data array. The tag array is written together with the last word.
- It feeds the fetch/memory stage directly: while fsm_busy is high, the cpu stalls the PC and pipeline.

Parameters:
WORDS_PER_BLOCK, 8, 16-bit words per cache block; must be a power of two; block bytes = 2*WORDS_PER_BLOCK.
MEM_LATENCY, 4, cycles from a request (memory_read high) to its memory_data_valid beat; the memory is fixed-latency and in-order.
ADDR_W, 16, byte address width.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  reset; asynchronous, active-low.
miss_detected  input  1  cache reports a miss this cycle.
miss_address  input  ADDR_W  byte address that missed.
memory_data_valid  input  1  memory_data carries the next in-order beat.
memory_data  input  16  returned memory word.
fsm_busy  output  1  fill in progress; cpu stalls.
memory_read  output  1  issue a read request this cycle.
memory_address  output  ADDR_W  request byte address.
write_data_array  output  1  write cache_data at cache_word_addr.
cache_word_addr  output  ADDR_W  byte address of the word being written.
cache_data  output  16  equals memory_data (pass-through).
write_tag_array  output  1  one-cycle pulse: write tag/valid for fill_base.
protocol_err  output  1  sticky error flag; cleared only by reset.

Behaviour:
- States: IDLE, FILL.
- Registers: fill_base, issue_cnt, recv_cnt, state, protocol_err.
- Reset (async, rst_n=0): state=IDLE, both counters=0, protocol_err=0. All outputs go to 0 immediately.
- IDLE:
  - fsm_busy=0, memory_read=0.
  - If miss_detected=1 at a rising edge: latch fill_base = miss_address with the low log2(2*WORDS_PER_BLOCK) bits cleared (0xFFF0 mask at defaults), clear both counters, go to FILL.
- FILL, issue side:
  - fsm_busy=1.
  - While issue_cnt<WORDS_PER_BLOCK: memory_read=1, memory_address=fill_base+2*issue_cnt; issue_cnt increments each cycle.
  - Afterwards memory_read=0.
- FILL, receive side:
  - On each memory_data_valid=1: write_data_array=1 (combinational), cache_word_addr=fill_base+2*recv_cnt, cache_data=memory_data; recv_cnt increments.
  - Issue and receive overlap freely.
- Completion:
  - On the beat where recv_cnt==WORDS_PER_BLOCK-1, write_tag_array=1 in the same cycle as the final data write.
  - The FSM returns to IDLE at that cycle's closing edge.
- Timing at defaults, miss sampled at edge E0:
  - Requests in cycles 1..8.
  - Beats in cycles 5..12.
  - Tag pulse in cycle 12.
  - fsm_busy high in cycles 1..12, i.e. 12 cycles total.
  - General form: busy = WORDS_PER_BLOCK + MEM_LATENCY cycles.
- Address arithmetic: wraps modulo 2^ADDR_W. A block never crosses the wrap because base is aligned, so 0xFFFE gives base 0xFFF0 and last word 0xFFFE.
- miss_detected and miss_address are ignored in FILL. The latched fill_base is used for the whole fill.
- Back-to-back misses: miss_detected is re-sampled only in IDLE. The earliest next fill starts one IDLE cycle after completion.
- memory_data_valid with no outstanding request (state IDLE, or recv_cnt==issue_cnt):
  - No write occurs and no counter changes.
  - protocol_err is set.
- Reset mid-fill aborts the fill: no tag write occurs, and the block stays invalid in the cache. The memory model shares rst_n, so no stale beats return after reset.
- Counter widths: log2(WORDS_PER_BLOCK)+1 bits, with no overflow inside a fill.

Decomposition:
- Package cache_pkg:
  - fill_state_t enum {IDLE, FILL}.
  - BLOCK_BYTES, OFFSET_BITS, WORD_BYTES=2.
  - block_base() alignment function.
- One sub-module, beat_counter: enable/clear/count/done, parameterised by limit.
  - Instantiated twice: issue counter and receive counter.
- The FSM and address generation stay in cache_fill_fsm.

Test Plan:
1. miss_address=0x1236 pulsed at E0 → memory_address 0x1230,0x1232,…,0x123E in cycles 1-8 with memory_read=1; beats D0-D7 in cycles 5-12 written to 0x1230..0x123E; write_tag_array=1 only in cycle 12; fsm_busy high in cycles 1-12; protocol_err=0.
2. miss_address=0xFFFE → base 0xFFF0; last request and last write at 0xFFFE; no address reaches 0x0000.
3. miss_detected held high with miss_address changed to 0x4000 during a fill of 0x1230 → all writes stay in 0x1230-0x123E; a second fill at base 0x4000 starts after one IDLE cycle with fsm_busy=0.
4. rst_n driven low in cycle 6 (mid-fill) → all outputs 0 immediately, state IDLE, no write_tag_array pulse; after release, a new miss at 0x0080 fills correctly.
5. memory_data_valid=1 while IDLE → no write_data_array, protocol_err=1 and it stays 1 through a following normal fill until reset.
